sdram_writeback: RTL
====================

SDRAM_WRITEBACK -- requirements
Module: sdram_writeback

Interface
REQ-001 SHALL have parameter N, default 176; result vector length in int8 elements.
REQ-002 SHALL have parameter SDRAM_DATA_W, default 128; SDRAM write beat width in bits, a multiple of 8.
REQ-003 SHALL have parameter ADDR_W, default 32; SDRAM byte-address width.
REQ-004 SHALL derive BEATS = ceil(N*8 / SDRAM_DATA_W), which is 11 at defaults, and BYTES_PER_BEAT = SDRAM_DATA_W/8.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  one-cycle writeback request.
REQ-008 addr  input  ADDR_W  base byte address, sampled with start.
REQ-009 data  input  N*8  EU result vector (element i at bits [8i+7:8i]), sampled with start.
REQ-010 wr_valid  output  1  write beat offered.
REQ-011 wr_ready  input  1  SDRAM side accepts; a beat transfers when wr_valid and wr_ready are both high on a rising edge.
REQ-012 wr_addr  output  ADDR_W  byte address of the current beat.
REQ-013 wr_data  output  SDRAM_DATA_W  beat payload.
REQ-014 wr_be  output  SDRAM_DATA_W/8  byte enables of the current beat.
REQ-015 busy  output  1  high while not IDLE.
REQ-016 done  output  1  one-cycle pulse at writeback completion.

Function
REQ-017 SHALL implement an FSM with states IDLE, SEND and DONE.
REQ-018 IDLE with start=1: capture data into a snapshot register, capture addr, clear the beat counter to 0, and go to SEND next cycle.
REQ-019 start SHALL be ignored in SEND and DONE; the snapshot SHALL NOT change until the next accepted start.
REQ-020 SEND: wr_valid=1; wr_data = snapshot bits [(k+1)*SDRAM_DATA_W-1 : k*SDRAM_DATA_W] for beat k; wr_addr = addr + k*BYTES_PER_BEAT (modulo 2^ADDR_W, wrap without error).
REQ-021 In the last beat, snapshot bits beyond N*8 SHALL be driven 0; wr_be SHALL be set only for bytes below N*8.
REQ-022 wr_be SHALL be all-ones in all other beats, and all-zero whenever wr_valid=0.
REQ-023 Once wr_valid is asserted, wr_valid, wr_addr, wr_data and wr_be SHALL hold stable until the handshake; there is no retraction.
REQ-024 On handshake with k < BEATS-1, k SHALL increment and wr_valid SHALL stay high (back-to-back beats allowed).
REQ-025 On handshake with k = BEATS-1, the FSM SHALL go to DONE.
REQ-026 DONE SHALL assert done=1 and wr_valid=0 for exactly one cycle, then return to IDLE.
REQ-027 A start arriving in the DONE cycle SHALL be ignored.
REQ-028 Latency: with start at cycle 0 and wr_ready held high, beats SHALL transfer on cycles 1..BEATS and done SHALL be high on cycle BEATS+1.
REQ-029 Each cycle of wr_ready=0 during SEND SHALL add exactly one cycle of latency.
REQ-030 busy SHALL be 1 in SEND and DONE, and 0 in IDLE.
REQ-031 wr_ready while wr_valid=0 SHALL have no effect.

Reset
REQ-032 rst_n low SHALL immediately, without waiting for clk, force: state IDLE; wr_valid, done and busy = 0; wr_addr, wr_data, wr_be, snapshot and beat counter = 0.
REQ-033 Reset mid-SEND SHALL abandon the transfer with no further beats and no done pulse; the first start after reset release SHALL begin a fresh writeback from beat 0.

Verification
REQ-034 N=176, W=128, addr=0x1000, data element i = i, wr_ready=1 -> 11 beats at 0x1000, 0x1010 ... 0x10A0; beat 0 bytes 0x00..0x0F; done at cycle 12.
REQ-035 Same stimulus, wr_ready low on odd cycles -> identical beat sequence, signals stable while stalled, done at cycle 12 + number of stall cycles.
REQ-036 N=20, W=128, data all 0xFF -> 2 beats; beat 1 wr_data = 0x000000000000000000000000FFFFFFFF, wr_be = 0x000F.
REQ-037 start pulsed on the cycle of beat 5 and again in the DONE cycle -> ignored; exactly 11 beats and one done pulse.
REQ-038 rst_n low during beat 4 -> wr_valid drops asynchronously with no done; a new start at addr=0x2000 -> 11 beats beginning at 0x2000.
REQ-039 addr=0xFFFFFFF0 -> beat 1 at 0x00000000 (wrap); all 11 beats issued.

Source files
------------

// File: rtl/sdram_writeback.sv
// sdram_writeback: streams a captured int8 result vector to SDRAM as a
// burst of full-width write beats with a valid/ready handshake.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        one-cycle writeback request (honoured only when idle)
//   addr, data   base byte address and result vector, sampled with start
//   wr_valid     beat offered; transfers when wr_valid && wr_ready
//   wr_ready     SDRAM side accepts the current beat
//   wr_addr      byte address of the current beat
//   wr_data      beat payload (zero-padded past the vector end)
//   wr_be        byte enables (trimmed on the final beat)
//   busy, done   activity flag and one-cycle completion pulse
module sdram_writeback #(
    parameter int N            = 176,
    parameter int SDRAM_DATA_W = 128,
    parameter int ADDR_W       = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [ADDR_W-1:0]         addr,
    input  logic [N*8-1:0]            data,
    output logic                      wr_valid,
    input  logic                      wr_ready,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [SDRAM_DATA_W-1:0]   wr_data,
    output logic [SDRAM_DATA_W/8-1:0] wr_be,
    output logic                      busy,
    output logic                      done
);

    localparam int BEATS          = (N * 8 + SDRAM_DATA_W - 1) / SDRAM_DATA_W;
    localparam int BYTES_PER_BEAT = SDRAM_DATA_W / 8;
    localparam int KW             = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int SNAP_W         = BEATS * SDRAM_DATA_W;
    localparam int LAST_BYTES     = N - (BEATS - 1) * BYTES_PER_BEAT;

    localparam logic [KW-1:0]             K_LAST  = KW'(BEATS - 1);
    localparam logic [BYTES_PER_BEAT-1:0] BE_FULL = '1;
    // Final beat enables only the bytes that still hold vector elements.
    localparam logic [BYTES_PER_BEAT-1:0] BE_LAST =
        BE_FULL >> (BYTES_PER_BEAT - LAST_BYTES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                                 state_q, state_d;
    logic   [BEATS-1:0][SDRAM_DATA_W-1:0]   snap_q, snap_d;
    logic   [ADDR_W-1:0]                    base_q, base_d;
    logic   [KW-1:0]                        k_q, k_d;
    logic                                   last_beat;

    assign last_beat = (k_q == K_LAST);

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            snap_q  <= '0;
            base_q  <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            base_q  <= base_d;
            k_q     <= k_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        base_d  = base_q;
        k_d     = k_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    // Zero-extension leaves the tail of the last beat at 0.
                    snap_d  = SNAP_W'(data);
                    base_d  = addr;
                    k_d     = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (wr_ready) begin
                    if (last_beat) begin
                        state_d = DONE;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from registers only, so they hold steady while
    // stalled and fall to zero as soon as reset clears the registers.
    always_comb begin
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        wr_be    = '0;
        done     = 1'b0;
        busy     = (state_q != IDLE);
        unique case (state_q)
            SEND: begin
                wr_valid = 1'b1;
                wr_data  = snap_q[k_q];
                wr_addr  = base_q + ADDR_W'(k_q) * ADDR_W'(BYTES_PER_BEAT);
                wr_be    = last_beat ? BE_LAST : BE_FULL;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                wr_valid = 1'b0;
            end
        endcase
    end

endmodule
